// File: rtl/acc_dump_sat_if.sv
// Stream bundle for the accumulate-and-dump stage: sample/flush inputs and frame-result outputs.
// master drives samples and receives results; slave is the accumulator side.
interface acc_dump_sat_if #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned LEN_W = 5
);

    logic [IN_W-1:0]  i_data;
    logic             i_valid;
    logic             i_flush;
    logic [OUT_W-1:0] o_data;
    logic             o_valid;
    logic [LEN_W-1:0] o_len;
    logic             o_sat;

    modport master (
        output i_data,
        output i_valid,
        output i_flush,
        input  o_data,
        input  o_valid,
        input  o_len,
        input  o_sat
    );

    modport slave (
        input  i_data,
        input  i_valid,
        input  i_flush,
        output o_data,
        output o_valid,
        output o_len,
        output o_sat
    );

endinterface

// File: rtl/acc_dump_sat.sv
// Accumulate-and-dump: integrates signed samples over a frame (or until flush), then emits the
// round-half-up rescaled, saturated sum with a single-cycle strobe. No backpressure.
module acc_dump_sat #(
    parameter int unsigned IN_W      = 13,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned LEN_W     = $clog2(FRAME_LEN + 1)
) (
    input logic           i_clk,
    input logic           i_rst,
    acc_dump_sat_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);

    // Saturation bounds held at the rounding width so comparisons stay signed and exact.
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    if (ACC_W < IN_W + $clog2(FRAME_LEN)) begin : g_bad_acc_w
        $error("acc_dump_sat: ACC_W too small for IN_W and FRAME_LEN");
    end
    if (FRAME_LEN < 2) begin : g_bad_frame_len
        $error("acc_dump_sat: FRAME_LEN must be at least 2");
    end
    if (SHIFT >= ACC_W) begin : g_bad_shift
        $error("acc_dump_sat: SHIFT must be below ACC_W");
    end
    if (OUT_W > ACC_W || OUT_W < 2) begin : g_bad_out_w
        $error("acc_dump_sat: OUT_W must be in 2..ACC_W");
    end

    // Accumulation state
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0] dreg_q, dreg_d;
    logic        [LEN_W-1:0] dlen_q, dlen_d;
    logic                    dpend_q, dpend_d;

    // Output registers
    logic        [OUT_W-1:0] o_data_q, o_data_d;
    logic        [LEN_W-1:0] o_len_q, o_len_d;
    logic                    o_sat_q, o_sat_d;
    logic                    o_valid_q, o_valid_d;

    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] nxt;
    logic        [LEN_W-1:0] nlen;
    logic                    last;
    logic                    dump;

    logic signed [ACC_W:0]   dreg_x;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   sat_val;
    logic                    clamp;

    always_comb begin
        din_ext = {{(ACC_W - IN_W){bus.i_data[IN_W-1]}}, bus.i_data};
        nxt     = bus.i_valid ? acc_q + din_ext : acc_q;
        nlen    = LEN_W'(cnt_q) + LEN_W'(bus.i_valid);
        last    = bus.i_valid && (cnt_q == CNT_W'(FRAME_LEN - 1));
        // A flush on an empty frame has nothing to report and is dropped.
        dump    = last || (bus.i_flush && (nlen != '0));
    end

    always_comb begin
        acc_d   = nxt;
        cnt_d   = CNT_W'(nlen);
        dreg_d  = dreg_q;
        dlen_d  = dlen_q;
        dpend_d = 1'b0;
        if (dump) begin
            dreg_d  = nxt;
            dlen_d  = nlen;
            dpend_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    assign dreg_x = signed'({dreg_q[ACC_W-1], dreg_q});

    if (SHIFT == 0) begin : g_no_round
        assign rnd = dreg_x;
    end else begin : g_round
        localparam logic signed [ACC_W:0] BIAS = (ACC_W + 1)'(1) << (SHIFT - 1);
        assign rnd = (dreg_x + BIAS) >>> SHIFT;
    end

    always_comb begin
        sat_val = rnd;
        clamp   = 1'b0;
        if (rnd > SAT_HI) begin
            sat_val = SAT_HI;
            clamp   = 1'b1;
        end else if (rnd < SAT_LO) begin
            sat_val = SAT_LO;
            clamp   = 1'b1;
        end
    end

    always_comb begin
        o_valid_d = dpend_q;
        o_data_d  = o_data_q;
        o_len_d   = o_len_q;
        o_sat_d   = o_sat_q;
        if (dpend_q) begin
            o_data_d = OUT_W'(sat_val);
            o_len_d  = dlen_q;
            o_sat_d  = clamp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            dreg_q    <= '0;
            dlen_q    <= '0;
            dpend_q   <= 1'b0;
            o_data_q  <= '0;
            o_len_q   <= '0;
            o_sat_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dreg_q    <= dreg_d;
            dlen_q    <= dlen_d;
            dpend_q   <= dpend_d;
            o_data_q  <= o_data_d;
            o_len_q   <= o_len_d;
            o_sat_q   <= o_sat_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_len   = o_len_q;
    assign bus.o_sat   = o_sat_q;
    assign bus.o_valid = o_valid_q;

endmodule

// File: tb/tb_acc_dump_sat.sv
// Directed bench for acc_dump_sat: a SHIFT=4 instance and a SHIFT=0 instance share one stimulus.
module tb_acc_dump_sat;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [12:0] din;
    logic              vld;
    logic              flu;

    int n_checks = 0;
    int n_errors = 0;
    int n_strb0  = 0;
    int s;

    always #5 clk = ~clk;

    acc_dump_sat_if #(.IN_W(13), .OUT_W(16), .LEN_W(5)) bus0 ();
    acc_dump_sat_if #(.IN_W(13), .OUT_W(16), .LEN_W(5)) bus1 ();

    assign bus0.i_data  = din;
    assign bus0.i_valid = vld;
    assign bus0.i_flush = flu;
    assign bus1.i_data  = din;
    assign bus1.i_valid = vld;
    assign bus1.i_flush = flu;

    acc_dump_sat #(.SHIFT(4)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    acc_dump_sat #(.SHIFT(0)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    always @(negedge clk) begin
        if (bus0.o_valid) n_strb0++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [12:0] d, input logic f);
        vld = v;
        din = d;
        flu = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 13'sd0, 1'b0);
    endtask

    task automatic frame(input int d, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 13'(d), 1'b0);
    endtask

    task automatic check_out(input string tag, input int d, input int len, input int sat);
        check({tag, ".valid"}, int'(bus0.o_valid), 1);
        check({tag, ".data"}, int'($signed(bus0.o_data)), d);
        check({tag, ".len"}, int'(bus0.o_len), len);
        check({tag, ".sat"}, int'(bus0.o_sat), sat);
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        din = '0;
        flu = 1'b0;
        repeat (3) step(1'b1, 13'sd500, 1'b0);
        check("rst.valid", int'(bus0.o_valid), 0);
        check("rst.data", int'(bus0.o_data), 0);
        check("rst.len", int'(bus0.o_len), 0);
        check("rst.sat", int'(bus0.o_sat), 0);
        rst = 1'b0;

        // Full frame +100 followed back-to-back by -100
        frame(100, 15);
        check("rst.nostrobe", n_strb0, 0);
        step(1'b1, 13'sd100, 1'b0);
        check("full.early", int'(bus0.o_valid), 0);
        step(1'b1, -13'sd100, 1'b0);
        check_out("full_pos", 100, 16, 0);
        check("full_pos.s0", int'($signed(bus1.o_data)), 1600);
        frame(-100, 15);
        idle();
        check_out("full_neg", -100, 16, 0);
        idle();
        check("full_neg.single", int'(bus0.o_valid), 0);

        // Round-half-up
        step(1'b1, 13'sd24, 1'b0);
        frame(0, 15);
        idle();
        check_out("rnd_p24", 2, 16, 0);
        idle();
        step(1'b1, -13'sd24, 1'b0);
        frame(0, 15);
        idle();
        check_out("rnd_m24", -1, 16, 0);
        idle();
        step(1'b1, 13'sd8, 1'b0);
        frame(0, 15);
        idle();
        check_out("rnd_p8", 1, 16, 0);
        idle();

        // Saturation on the unshifted instance
        frame(4095, 16);
        idle();
        check("sat_hi.data", int'($signed(bus1.o_data)), 32767);
        check("sat_hi.sat", int'(bus1.o_sat), 1);
        check_out("sat_hi.s4", 4095, 16, 0);
        idle();
        frame(-4096, 16);
        idle();
        check("sat_lo.data", int'($signed(bus1.o_data)), -32768);
        check("sat_lo.sat", int'(bus1.o_sat), 1);
        check_out("sat_lo.s4", -4096, 16, 0);
        idle();

        // Flush with idle gaps, then an empty flush
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 13'sd10, 1'b0);
            if (i < 4) repeat (i) idle();
        end
        step(1'b1, 13'sd10, 1'b1);
        idle();
        check_out("flush", 4, 6, 0);
        idle();
        s = n_strb0;
        step(1'b0, 13'sd0, 1'b1);
        idle();
        idle();
        check("flush_empty", n_strb0, s);

        // Flush coinciding with the last sample of a frame
        frame(3, 15);
        step(1'b1, 13'sd3, 1'b1);
        idle();
        check_out("flush_last", 3, 16, 0);
        idle();
        check("flush_last.single", int'(bus0.o_valid), 0);

        // Consecutive one-sample flushes
        step(1'b1, 13'sd32, 1'b1);
        step(1'b1, 13'sd32, 1'b1);
        check_out("one_a", 2, 1, 0);
        idle();
        check_out("one_b", 2, 1, 0);
        idle();
        check("one.end", int'(bus0.o_valid), 0);

        // Reset mid-frame
        s = n_strb0;
        frame(50, 8);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        frame(1, 16);
        idle();
        check_out("rst_mid", 1, 16, 0);
        idle();
        check("rst_mid.count", n_strb0, s + 1);

        // Reset on the edge right after a dump
        s = n_strb0;
        frame(7, 16);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("rst_dump.valid", int'(bus0.o_valid), 0);
        check("rst_dump.data", int'(bus0.o_data), 0);
        idle();
        idle();
        check("rst_dump.count", n_strb0, s);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_dump_sat.md
# acc_dump_sat

Accumulate-and-dump stage that consumes the 13-bit signed sum stream produced by the two-input adder stage and integrates it over a frame of FRAME_LEN valid samples. At frame end it rescales the sum with round-half-up, saturates it to OUT_W bits, and emits one result with a single-cycle valid strobe. It is a streaming block with no backpressure. Partial frames can be dumped early with a flush request.

## Interface

Parameters:
- IN_W, 13: input sample width, signed two's complement.
- ACC_W, 20: accumulator width. Must satisfy ACC_W ≥ IN_W + clog2(FRAME_LEN); elaboration fails otherwise.
- FRAME_LEN, 16: samples per frame, ≥ 2.
- SHIFT, 4: arithmetic right shift applied at dump, 0 ≤ SHIFT < ACC_W.
- OUT_W, 16: output width, signed, ≤ ACC_W.
- LEN_W, clog2(FRAME_LEN+1): width of the length field.

Ports:
- i_clk, input, 1: the only clock; all logic is rising-edge.
- i_rst, input, 1: synchronous, active-high reset.
- i_data, input, IN_W: signed sample.
- i_valid, input, 1: i_data is accepted on this edge.
- i_flush, input, 1: dump the current frame on this edge (see Operation).
- o_data, output, OUT_W: rounded, saturated frame result.
- o_valid, output, 1: single-cycle strobe; o_data, o_len and o_sat are valid.
- o_len, output, LEN_W: number of samples in the dumped frame.
- o_sat, output, 1: o_data was clamped.

## Operation

- State: accumulator `acc` (ACC_W, signed), sample counter `cnt` (0..FRAME_LEN-1), dump register `dreg`, dump length `dlen`, dump-pending flag `dpend`.
- Sum term: `nxt = acc + sext(i_data)` when i_valid, else `acc`. `nlen = cnt + i_valid`.
- Dump condition `dump` is true when either:
  - i_valid and cnt == FRAME_LEN-1, or
  - i_flush and nlen ≥ 1.
- On an edge with dump:
  - dreg ← nxt, dlen ← nlen, dpend ← 1.
  - acc ← 0, cnt ← 0.
- On an edge without dump:
  - acc ← nxt, cnt ← nlen, dpend ← 0.
- i_flush with an empty frame (nlen == 0) is ignored; no output is produced.
- Output stage, on the edge after dump, when dpend is 1:
  - r = (dreg + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits. With SHIFT = 0, r = dreg.
  - Saturate r to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_data ← saturated r, o_sat ← 1 if clamped, o_len ← dlen, o_valid ← 1.
- When dpend is 0: o_valid ← 0. o_data, o_len and o_sat hold their last values.
- No internal wrap: the parameter constraint guarantees acc cannot overflow.
- Simultaneous events:
  - i_flush together with the FRAME_LEN-th sample produces a single dump of FRAME_LEN samples.
  - i_valid and i_flush together include the sample in the dumped frame.
- Reset (i_rst = 1 on an edge) overrides everything:
  - acc, cnt, dreg, dlen and dpend clear to 0.
  - o_data, o_len, o_sat and o_valid clear to 0.
  - A partial frame or a pending dump is discarded; no strobe is emitted for it.

## Timing

- Reset values: o_data = 0, o_len = 0, o_sat = 0, o_valid = 0.
- Latency: the last sample of a frame is sampled at edge k. o_valid is high for exactly the cycle after edge k+1, i.e. 2 clocks after the sampling edge.
- Back-to-back frames are supported: the first sample of the next frame may arrive at edge k+1. Throughput is one sample per clock.
- o_valid is never high on two consecutive cycles, since FRAME_LEN ≥ 2. One exception: consecutive flushes of 1-sample frames give one strobe per flush.
- i_valid gaps of any length are allowed; cnt holds across gaps.
- There is no ready input; the downstream stage must accept every strobe.

## Test plan

- **Reset:** hold i_rst for 3 edges with i_valid = 1, i_data = 500 → o_valid stays 0, all outputs 0, no strobe after release until 16 new samples arrive.
- **Full frame:** 16 contiguous samples of +100 → one strobe 2 clocks after the 16th edge with o_data = 100, o_len = 16, o_sat = 0. A second contiguous frame of -100 → o_data = -100 with no gap between frames.
- **Rounding:** frame summing to +24 → o_data = 2. Frame summing to -24 → o_data = -1. Frame summing to +8 → o_data = 1.
- **Saturation (SHIFT = 0):** 16 × +4095 → o_data = 32767, o_sat = 1. 16 × -4096 → o_data = -32768, o_sat = 1.
- **Flush with gaps:** 5 samples of 10 with 0–3 idle cycles between them, then i_flush with a 6th valid sample of 10 → o_data = 4 (sum 60), o_len = 6. A following flush with no samples in between → no strobe.
- **Reset mid-frame and mid-dump:**
  - 8 samples of 50, then reset, then 16 samples of 1 → o_data = 1, o_len = 16.
  - Reset on the edge right after a dump → no strobe for that frame.
